pulse_gen: RTL

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen_pkg.sv | 13 +
 rtl/pulse_gen_timer.sv | 30 +++
 rtl/pulse_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_PEND_W = 4;

endpackage

// File: rtl/pulse_gen_timer.sv
// Up-counting phase timer shared by the HIGH and GAP phases.
// o_done is high in the last cycle of a phase of max(i_len,1) cycles.
module pulse_gen_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;

    // A zero length behaves like one, so the last count is never below 0.
    assign w_last = (i_len == '0) ? '0 : i_len - 1'b1;
    assign o_done = (r_cnt == w_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= '0;
        else if (i_start && !o_done)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/pulse_gen.sv
// Triggered pulse shaper: programmable high/low time, optional request queue.
// Define PULSE_GEN_QUEUE_EN to queue triggers that arrive while busy.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trigger,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  gap,
    output logic              pulse,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    state_t           r_state, w_nstate;
    logic [CNT_W-1:0] r_width, r_gap, w_len;
    logic             r_pulse, r_ovf;
    logic             w_done, w_load, w_launch, w_busy_trig, w_drop;

    assign w_len = (r_state == HIGH) ? r_width : r_gap;
    // Every state change starts a fresh phase, including GAP->HIGH relaunches.
    assign w_load = (w_nstate != r_state);

    pulse_gen_timer #(.CNT_W(CNT_W)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_load),
        .i_start (busy),
        .i_len   (w_len),
        .o_done  (w_done)
    );

`ifdef PULSE_GEN_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0] r_pend;
    logic              w_deq, w_enq;
`endif

    always_comb begin
        w_nstate = r_state;
        w_launch = 1'b0;
`ifdef PULSE_GEN_QUEUE_EN
        w_deq    = 1'b0;
`endif
        case (r_state)
            IDLE: if (trigger) begin
                w_nstate = HIGH;
                w_launch = 1'b1;
            end
            HIGH: if (w_done) w_nstate = GAP;
            GAP: if (w_done) begin
`ifdef PULSE_GEN_QUEUE_EN
                if (r_pend != '0) begin
                    w_nstate = HIGH;
                    w_launch = 1'b1;
                    w_deq    = 1'b1;
                end else if (trigger) begin
                    w_nstate = HIGH;
                    w_launch = 1'b1;
                end else begin
                    w_nstate = IDLE;
                end
`else
                w_nstate = IDLE;
`endif
            end
            default: w_nstate = IDLE;
        endcase
    end

`ifdef PULSE_GEN_QUEUE_EN
    // A trigger that directly relaunches at GAP end is consumed, not queued.
    assign w_busy_trig = trigger && (r_state != IDLE) &&
                         !((r_state == GAP) && w_done && (r_pend == '0));
    assign w_enq   = w_busy_trig && ((r_pend != PEND_MAX) || w_deq);
    assign w_drop  = w_busy_trig && !w_enq;
    assign pending = r_pend;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_pend <= '0;
        else if (w_enq && !w_deq)
            r_pend <= r_pend + 1'b1;
        else if (w_deq && !w_enq)
            r_pend <= r_pend - 1'b1;
    end
`else
    assign w_busy_trig = trigger && (r_state != IDLE);
    assign w_drop      = w_busy_trig;
    assign pending     = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
            r_ovf   <= 1'b0;
            r_width <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nstate;
            r_pulse <= (w_nstate == HIGH);
            if (w_drop)
                r_ovf <= 1'b1;
            if (w_launch) begin
                r_width <= width;
                r_gap   <= gap;
            end
        end
    end

    assign pulse    = r_pulse;
    assign busy     = (r_state != IDLE);
    assign overflow = r_ovf;

endmodule
